// File: rtl/hw_cpu_oci_trace_pkg.sv
// Shared types and helpers for the OCI trace capture buffer.
//   trace_state_e : capture state machine encoding
//   entry_width   : width of one stored FIFO entry {count, data}
//   sat_inc       : saturating increment for the dropped-word counter
package hw_cpu_oci_trace_pkg;

  typedef enum logic [1:0] {
    StCapture = 2'd0,
    StDrain   = 2'd1,
    StDone    = 2'd2
  } trace_state_e;

  function automatic int unsigned entry_width(input int unsigned data_w,
                                              input int unsigned count_w);
    return data_w + count_w;
  endfunction

  // Valid for widths 1..63; the value is held once it reaches all-ones.
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
    logic [63:0] max_v;
    max_v = (64'd1 << width) - 64'd1;
    return (val >= max_v) ? val : val + 64'd1;
  endfunction

endpackage

// File: rtl/hw_cpu_oci_trace_fifo.sv
// Generic show-ahead synchronous FIFO.
//   clk_i, rst_i      : clock, synchronous active-high reset
//   push_i, wdata_i   : write request and data (ignored when full unless popping)
//   pop_i             : advance head (ignored when empty)
//   rdata_o           : head entry, valid whenever empty_o=0
//   full_o, empty_o   : occupancy flags
//   level_o           : occupancy 0..DEPTH
module hw_cpu_oci_trace_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Extra MSB on each pointer distinguishes full from empty.
  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/hw_cpu_oci_trace_buffer.sv
// OCI data-capture-trace buffer: queues {dct_count, dct_buffer} entries for a debug
// reader, counts words dropped on overflow and drains cleanly at end of test.
//   clk, reset                  : clock, synchronous active-high reset
//   dct_buffer/count/valid      : trace word input; count=0 means nothing to capture
//   test_ending, test_has_ended : end-of-test sequencing
//   rd_ready/valid/data/count   : show-ahead read port
//   level, overflow, drop_cnt   : occupancy and loss accounting
//   capturing, done             : state indication
module hw_cpu_oci_trace_buffer
  import hw_cpu_oci_trace_pkg::*;
#(
  parameter int unsigned DATA_W  = 30,
  parameter int unsigned COUNT_W = 4,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned DROP_W  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          dct_buffer,
  input  logic [COUNT_W-1:0]         dct_count,
  input  logic                       dct_valid,
  input  logic                       test_ending,
  input  logic                       test_has_ended,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [DATA_W-1:0]          rd_data,
  output logic [COUNT_W-1:0]         rd_count,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       overflow,
  output logic [DROP_W-1:0]          drop_cnt,
  output logic                       capturing,
  output logic                       done
);

  localparam int unsigned EntryW = entry_width(DATA_W, COUNT_W);
  localparam int unsigned LevelW = $clog2(DEPTH+1);

  trace_state_e        state_q, state_d;
  logic                overflow_q, overflow_d;
  logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic                fifo_full, fifo_empty;
  logic [LevelW-1:0]   fifo_level;
  logic [EntryW-1:0]   head;
  logic                pop, push_offer, push_ok, drop, empty_after;

  assign rd_valid   = !fifo_empty && (state_q != StDone);
  assign pop        = rd_valid && rd_ready;
  assign push_offer = (state_q == StCapture) && dct_valid && (dct_count != '0);
  assign push_ok    = push_offer && (!fifo_full || pop);
  assign drop       = push_offer && !push_ok;
  // No pushes happen outside capture, so only the pop can change level while draining.
  assign empty_after = (fifo_level == '0) || ((fifo_level == LevelW'(1)) && pop);

  hw_cpu_oci_trace_fifo #(
    .WIDTH (EntryW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .push_i  (push_ok),
    .wdata_i ({dct_count, dct_buffer}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StCapture: if (test_ending || test_has_ended) state_d = StDrain;
      StDrain:   if (empty_after && test_has_ended) state_d = StDone;
      StDone:    state_d = StDone;
      default:   state_d = StCapture;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop) begin
      overflow_d = 1'b1;
      drop_cnt_d = DROP_W'(sat_inc(64'(drop_cnt_q), DROP_W));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StCapture;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign {rd_count, rd_data} = head;
  assign level     = fifo_level;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;
  assign capturing = (state_q == StCapture);
  assign done      = (state_q == StDone);

endmodule

// File: tb/tb_hw_cpu_oci_trace_buffer.sv
module tb_hw_cpu_oci_trace_buffer;

  localparam int unsigned DATA_W  = 30;
  localparam int unsigned COUNT_W = 4;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned DROP_W  = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic [DATA_W-1:0]  dct_buffer;
  logic [COUNT_W-1:0] dct_count;
  logic               dct_valid, test_ending, test_has_ended, rd_ready;
  logic               rd_valid, overflow, capturing, done;
  logic [DATA_W-1:0]  rd_data;
  logic [COUNT_W-1:0] rd_count;
  logic [4:0]         level;
  logic [DROP_W-1:0]  drop_cnt;

  hw_cpu_oci_trace_buffer #(
    .DATA_W  (DATA_W),
    .COUNT_W (COUNT_W),
    .DEPTH   (DEPTH),
    .DROP_W  (DROP_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .dct_valid      (dct_valid),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended),
    .rd_ready       (rd_ready),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .rd_count       (rd_count),
    .level          (level),
    .overflow       (overflow),
    .drop_cnt       (drop_cnt),
    .capturing      (capturing),
    .done           (done)
  );

  always #5 clk = ~clk;

  // Scoreboard and reference state.
  logic [33:0] sb_q[$];
  int          m_state;   // 0 capture, 1 drain, 2 done
  int          m_drop;
  logic        m_ovf;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag);
    chk({tag, ".level"}, 64'(level), 64'(sb_q.size()));
    chk({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
    chk({tag, ".drop_cnt"}, 64'(drop_cnt), 64'(m_drop));
    chk({tag, ".capturing"}, 64'(capturing), 64'(m_state == 0));
    chk({tag, ".done"}, 64'(done), 64'(m_state == 2));
  endtask

  task automatic do_reset();
    reset = 1'b1; dct_valid = 1'b0; dct_buffer = '0; dct_count = '0;
    test_ending = 1'b0; test_has_ended = 1'b0; rd_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    sb_q.delete(); m_state = 0; m_drop = 0; m_ovf = 1'b0;
    chk("reset.rd_valid", 64'(rd_valid), 64'd0);
    chk_status("reset");
  endtask

  // One clock cycle: drive, check head/pop against the scoreboard, update model, check status.
  task automatic cycle(input string tag, input logic v, input logic [DATA_W-1:0] d,
                       input logic [COUNT_W-1:0] c, input logic rdy, input logic te,
                       input logic the);
    logic exp_valid, popping;
    logic [33:0] head;
    dct_valid = v; dct_buffer = d; dct_count = c;
    rd_ready = rdy; test_ending = te; test_has_ended = the;
    #1;
    exp_valid = (sb_q.size() > 0) && (m_state != 2);
    chk({tag, ".rd_valid"}, 64'(rd_valid), 64'(exp_valid));
    popping = exp_valid && rdy;
    if (popping) begin
      head = sb_q.pop_front();
      chk({tag, ".rd_data"}, 64'(rd_data), 64'(head[29:0]));
      chk({tag, ".rd_count"}, 64'(rd_count), 64'(head[33:30]));
    end
    if (m_state == 0 && v && c != '0) begin
      if (sb_q.size() < DEPTH || popping) sb_q.push_back({c, d});
      else begin
        m_ovf = 1'b1;
        if (m_drop < 65535) m_drop++;
      end
    end
    if (m_state == 0) begin
      if (te || the) m_state = 1;
    end else if (m_state == 1) begin
      if (sb_q.size() == 0 && the) m_state = 2;
    end
    @(posedge clk); #1;
    chk_status(tag);
  endtask

  initial begin
    do_reset();

    // Basic flow.
    cycle("basic.push0", 1, 30'h1, 4'd4, 0, 0, 0);
    cycle("basic.push1", 1, 30'h2, 4'd2, 0, 0, 0);
    cycle("basic.push2", 1, 30'h3, 4'd1, 0, 0, 0);
    chk("basic.level3", 64'(level), 64'd3);
    chk("basic.head_data", 64'(rd_data), 64'h1);
    chk("basic.head_count", 64'(rd_count), 64'd4);
    for (int i = 0; i < 3; i++) cycle("basic.pop", 0, '0, '0, 1, 0, 0);
    cycle("basic.idle", 0, '0, '0, 0, 0, 0);
    chk("basic.rd_valid_empty", 64'(rd_valid), 64'd0);

    // Zero count is neither pushed nor dropped.
    for (int i = 0; i < 5; i++) cycle("zero", 1, 30'h3ff, 4'd0, 0, 0, 0);

    // Overflow: 20 pushes into 16 slots.
    for (int i = 0; i < 20; i++)
      cycle("ovf.push", 1, DATA_W'(i), COUNT_W'((i % 15) + 1), 0, 0, 0);
    chk("ovf.level", 64'(level), 64'd16);
    chk("ovf.drop_cnt", 64'(drop_cnt), 64'd4);
    chk("ovf.overflow", 64'(overflow), 64'd1);

    // Full plus simultaneous pop: push accepted, no drop.
    cycle("full.pushpop", 1, 30'h100, 4'd7, 1, 0, 0);
    chk("full.level", 64'(level), 64'd16);
    chk("full.drop_cnt", 64'(drop_cnt), 64'd4);
    for (int i = 0; i < 16; i++) cycle("full.drain", 0, '0, '0, 1, 0, 0);

    // End of test.
    do_reset();
    for (int i = 0; i < 5; i++) cycle("eot.push", 1, DATA_W'(30'h50 + i), 4'd3, 0, 0, 0);
    cycle("eot.pulse", 0, '0, '0, 0, 1, 1);
    chk("eot.capturing", 64'(capturing), 64'd0);
    cycle("eot.ign0", 1, 30'h77, 4'd5, 0, 0, 1);
    cycle("eot.ign1", 1, 30'h78, 4'd5, 0, 0, 1);
    chk("eot.level_held", 64'(level), 64'd5);
    chk("eot.no_drop", 64'(drop_cnt), 64'd0);
    for (int i = 0; i < 5; i++) cycle("eot.pop", 0, '0, '0, 1, 0, 1);
    chk("eot.done", 64'(done), 64'd1);
    cycle("eot.after", 1, 30'h9, 4'd1, 1, 0, 1);

    // Reset mid-drain with level 7 and overflow set.
    do_reset();
    for (int i = 0; i < 17; i++) cycle("rmd.fill", 1, DATA_W'(i), 4'd2, 0, 0, 0);
    for (int i = 0; i < 9; i++) cycle("rmd.pop", 0, '0, '0, 1, 0, 0);
    cycle("rmd.end", 0, '0, '0, 0, 1, 0);
    chk("rmd.level7", 64'(level), 64'd7);
    chk("rmd.ovf_set", 64'(overflow), 64'd1);
    chk("rmd.draining", 64'(capturing), 64'd0);
    do_reset();
    cycle("rmd.push", 1, 30'h2a, 4'd9, 0, 0, 0);
    cycle("rmd.popnew", 0, '0, '0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
